// File: rtl/seq_edge_8b_pos_gen.sv
// Eight independent edge generators: each input event becomes one high pulse
// followed by a guaranteed low gap; events arriving while busy are queued per lane.
module seq_edge_8b_pos_gen #(
    parameter int HIGH_CYCLES = 1,
    parameter int LOW_CYCLES  = 1,
    parameter int PEND_W      = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_,
    output logic [7:0] out,
    output logic [7:0] busy,
    output logic [7:0] overflow
);
    localparam int LANES   = 8;
    localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Saturating pending update: +event -launch, held at PEND_MAX when full.
    function automatic logic [PEND_W-1:0] pend_next(
        input logic [PEND_W-1:0] pend,
        input logic              ev,
        input logic              launch
    );
        logic [PEND_W-1:0] res;
        res = pend;
        if (ev && !launch && (pend != PEND_MAX))
            res = pend + 1'b1;
        else if (!ev && launch)
            res = pend - 1'b1;
        return res;
    endfunction

    function automatic logic pend_drop(
        input logic [PEND_W-1:0] pend,
        input logic              ev,
        input logic              launch
    );
        return ev && !launch && (pend == PEND_MAX);
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_t            state;
        logic [CNT_W-1:0]  cnt;
        logic [PEND_W-1:0] pend;
        logic              out_r;
        logic              ovf_r;
        logic              want;
        logic              last;
        logic              launch;

        // A launch from the last GAP cycle chains straight into HIGH.
        always_comb begin
            want   = in_[i] || (pend != '0);
            last   = (cnt == '0);
            launch = want && ((state == IDLE) || ((state == GAP) && last));
        end

        // ---- lane register stage ----
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= IDLE;
                cnt   <= '0;
                pend  <= '0;
                out_r <= 1'b0;
                ovf_r <= 1'b0;
            end else begin
                pend <= pend_next(pend, in_[i], launch);
                if (pend_drop(pend, in_[i], launch))
                    ovf_r <= 1'b1;

                if (launch) begin
                    state <= HIGH;
                    cnt   <= HIGH_LOAD;
                    out_r <= 1'b1;
                end else begin
                    case (state)
                        HIGH: begin
                            if (last) begin
                                state <= GAP;
                                cnt   <= LOW_LOAD;
                                out_r <= 1'b0;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                        GAP: begin
                            if (last)
                                state <= IDLE;
                            else
                                cnt <= cnt - 1'b1;
                        end
                        IDLE: begin
                            out_r <= 1'b0;
                        end
                        default: begin
                            state <= IDLE;
                            out_r <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign out[i]      = out_r;
        assign overflow[i] = ovf_r;
        assign busy[i]     = (state != IDLE) || (pend != '0);
    end

endmodule
